// File: rtl/proj_to_affine_if.sv
// Request/response bundle for proj_to_affine. o_error only exists when PTA_ZCHK_EN is defined.
interface proj_to_affine_if;
    logic         i_start;
    logic [254:0] i_x;
    logic [254:0] i_y;
    logic [254:0] i_z;
    logic [254:0] o_x;
    logic [254:0] o_y;
    logic         o_busy;
    logic         o_finished;
`ifdef PTA_ZCHK_EN
    logic         o_error;

    modport slave  (input  i_start, i_x, i_y, i_z,
                    output o_x, o_y, o_busy, o_finished, o_error);
    modport master (output i_start, i_x, i_y, i_z,
                    input  o_x, o_y, o_busy, o_finished, o_error);
`else
    modport slave  (input  i_start, i_x, i_y, i_z,
                    output o_x, o_y, o_busy, o_finished);
    modport master (output i_start, i_x, i_y, i_z,
                    input  o_x, o_y, o_busy, o_finished);
`endif
endinterface

// File: rtl/proj_to_affine.sv
// Projective (X,Y,Z) -> affine (X/Z, Y/Z) mod 2^255-19 via Fermat inversion on one Montgomery multiplier.
// Optional macro PTA_ZCHK_EN: Z == 0 is short-circuited to (0,0) with o_error.
module pta_mont #(
    parameter int DIGITS = 51   // radix-2 steps per cycle; must divide 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [254:0] a_i,
    input  logic [254:0] b_i,
    output logic [254:0] res_o,
    output logic         finished_o
);
    localparam logic [254:0] P     = '1 - 255'd18;
    localparam int           LAST  = 255 / DIGITS - 1;

    logic         busy_q, fin_q;
    logic [2:0]   cnt_q;
    logic [254:0] a_q, b_q, res_q, red;
    logic [256:0] t_q, t_d;

    // Each step: t = (t + a_i*b + m*p) / 2 keeps t < 2p, so 257 bits suffice.
    always_comb begin
        t_d = t_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (a_q[k]) t_d = t_d + {2'b00, b_q};
            if (t_d[0]) t_d = t_d + {2'b00, P};
            t_d = t_d >> 1;
        end
        red = (t_d >= {2'b00, P}) ? 255'(t_d - {2'b00, P}) : t_d[254:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            fin_q  <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            t_q    <= '0;
            res_q  <= '0;
        end else begin
            fin_q <= 1'b0;
            if (start_i && !busy_q) begin
                busy_q <= 1'b1;
                cnt_q  <= '0;
                a_q    <= a_i;
                b_q    <= b_i;
                t_q    <= '0;
            end else if (busy_q) begin
                t_q   <= t_d;
                a_q   <= a_q >> DIGITS;
                cnt_q <= cnt_q + 3'd1;
                if (cnt_q == 3'(LAST)) begin
                    busy_q <= 1'b0;
                    fin_q  <= 1'b1;
                    res_q  <= red;
                end
            end
        end
    end

    assign res_o      = res_q;
    assign finished_o = fin_q;
endmodule

module proj_to_affine (
    input logic              i_clk,
    input logic              i_rst,
    proj_to_affine_if.slave  bus
);
    localparam logic [254:0] R_MOD_P  = 255'd19;
    localparam logic [254:0] R2_MOD_P = 255'd361;
    localparam logic [254:0] EXP      = '1 - 255'd20;

    typedef enum logic [2:0] {S_IDLE, S_TOMONT, S_SQR, S_MUL, S_XOUT, S_YOUT} state_e;

    state_e       state_q, state_d;
    logic         issued_q, issued_d, mul_start_q, mul_start_d;
    logic         busy_q, busy_d, fin_q, fin_d, err_q, err_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [254:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [254:0] acc_q, acc_d, zm_q, zm_d;
    logic [254:0] x_q, x_d, y_q, y_d, z_q, z_d, xs_q, xs_d;
    logic [254:0] ox_q, ox_d, oy_q, oy_d, sel_a, sel_b;
    logic [254:0] mul_res;
    logic         mul_fin;

    pta_mont u_mul (
        .clk       (i_clk),
        .rst       (i_rst),
        .start_i   (mul_start_q),
        .a_i       (op_a_q),
        .b_i       (op_b_q),
        .res_o     (mul_res),
        .finished_o(mul_fin)
    );

    always_comb begin
        case (state_q)
            S_TOMONT: begin sel_a = z_q;   sel_b = R2_MOD_P; end
            S_SQR:    begin sel_a = acc_q; sel_b = acc_q;    end
            S_MUL:    begin sel_a = acc_q; sel_b = zm_q;     end
            S_XOUT:   begin sel_a = x_q;   sel_b = acc_q;    end
            S_YOUT:   begin sel_a = y_q;   sel_b = acc_q;    end
            default:  begin sel_a = '0;    sel_b = '0;       end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        mul_start_d = 1'b0;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        acc_d       = acc_q;
        zm_d        = zm_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        xs_d        = xs_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        busy_d      = fin_q ? 1'b0 : busy_q;
        fin_d       = 1'b0;
        err_d       = 1'b0;

        if (state_q == S_IDLE) begin
            if (bus.i_start) begin
`ifdef PTA_ZCHK_EN
                if (bus.i_z == '0) begin
                    ox_d  = '0;
                    oy_d  = '0;
                    fin_d = 1'b1;
                    err_d = 1'b1;
                end else
`endif
                begin
                    x_d     = bus.i_x;
                    y_d     = bus.i_y;
                    z_d     = bus.i_z;
                    acc_d   = R_MOD_P;
                    cnt_d   = 8'd254;
                    busy_d  = 1'b1;
                    state_d = S_TOMONT;
                end
            end
        end else if (!issued_q) begin
            mul_start_d = 1'b1;
            op_a_d      = sel_a;
            op_b_d      = sel_b;
            issued_d    = 1'b1;
        end else if (mul_fin) begin
            issued_d = 1'b0;
            case (state_q)
                S_TOMONT: begin
                    zm_d    = mul_res;
                    state_d = S_SQR;
                end
                S_SQR: begin
                    acc_d = mul_res;
                    if (EXP[cnt_q])       state_d = S_MUL;
                    else if (cnt_q == '0) state_d = S_XOUT;
                    else                  cnt_d   = cnt_q - 8'd1;
                end
                S_MUL: begin
                    acc_d = mul_res;
                    if (cnt_q == '0) state_d = S_XOUT;
                    else begin
                        cnt_d   = cnt_q - 8'd1;
                        state_d = S_SQR;
                    end
                end
                S_XOUT: begin
                    xs_d    = mul_res;
                    state_d = S_YOUT;
                end
                default: begin
                    ox_d    = xs_q;
                    oy_d    = mul_res;
                    fin_d   = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            issued_q    <= 1'b0;
            mul_start_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            acc_q       <= '0;
            zm_q        <= '0;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            xs_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            mul_start_q <= mul_start_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            acc_q       <= acc_d;
            zm_q        <= zm_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            xs_q        <= xs_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            busy_q      <= busy_d;
            fin_q       <= fin_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_x        = ox_q;
    assign bus.o_y        = oy_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_finished = fin_q;
`ifdef PTA_ZCHK_EN
    assign bus.o_error    = err_q;
`endif
endmodule

// File: tb/tb_proj_to_affine.sv
// Scoreboard bench for proj_to_affine: driver pushes expected (x, y, mult count), monitor pops on o_finished.
module tb_proj_to_affine;
    localparam logic [254:0] P = '1 - 255'd18;
    localparam int LIMIT = 8000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proj_to_affine_if bus();
    proj_to_affine dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    typedef struct {
        logic [254:0] x;
        logic [254:0] y;
        int           nmul;
        int           base;
        int           t0;
        logic         err;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int mcount = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;
    initial forever begin
        @(negedge clk);
        if (dut.mul_start_q) mcount++;
    end

    task automatic chk(input string nm, input logic [254:0] act, input logic [254:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every o_finished against the oldest expectation.
    initial begin
        exp_t e;
        int   wait_cyc;
        bit   prev_fin;
        wait_cyc = 0;
        prev_fin = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_fin) chk("busy_after_fin", 255'(bus.o_busy), 255'd0);
            prev_fin = bus.o_finished;
            if (bus.o_finished) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_finished: got 1 want 0");
                end else begin
                    e = q.pop_front();
                    chk("o_x", bus.o_x, e.x);
                    chk("o_y", bus.o_y, e.y);
                    chk("mul_starts", 255'(mcount - e.base), 255'(e.nmul));
`ifdef PTA_ZCHK_EN
                    chk("o_error", 255'(bus.o_error), 255'(e.err));
                    if (e.err) chk("zchk_latency", 255'(cyc - e.t0), 255'd1);
`endif
                end
                wait_cyc = 0;
            end else if (q.size() != 0) begin
                wait_cyc++;
                if (wait_cyc > LIMIT) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout: got no o_finished within %0d cycles", LIMIT);
                    void'(q.pop_front());
                    wait_cyc = 0;
                end
            end
        end
    end

    task automatic issue(input logic [254:0] x, input logic [254:0] y, input logic [254:0] z,
                         input bit push, input logic [254:0] ex, input logic [254:0] ey,
                         input int nm, input logic er, input bit chkbusy);
        exp_t e;
        @(negedge clk);
        bus.i_x     = x;
        bus.i_y     = y;
        bus.i_z     = z;
        bus.i_start = 1'b1;
        if (push) begin
            e.x = ex; e.y = ey; e.nmul = nm; e.base = mcount; e.t0 = cyc; e.err = er;
            q.push_back(e);
        end
        @(negedge clk);
        bus.i_start = 1'b0;
        if (chkbusy) chk("busy_after_start", 255'(bus.o_busy), 255'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < LIMIT + 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        bus.i_start = 1'b0;
        bus.i_x = '0;
        bus.i_y = '0;
        bus.i_z = '0;
        #23;
        chk("rst_o_x", bus.o_x, '0);
        chk("rst_o_y", bus.o_y, '0);
        chk("rst_busy", 255'(bus.o_busy), '0);
        chk("rst_fin", 255'(bus.o_finished), '0);
        @(negedge clk);
        rst = 1'b0;

        // Identity denominator, then small and p-1 denominators.
        issue(255'd9, 255'd5, 255'd1, 1, 255'd9, 255'd5, 511, 1'b0, 1);
        wait_done();
        issue(255'd4, 255'd6, 255'd2, 1, 255'd2, 255'd3, 511, 1'b0, 1);
        wait_done();
        issue(255'd5, 255'd7, P - 255'd1, 1, P - 255'd5, P - 255'd7, 511, 1'b0, 1);
        wait_done();

        // A start while busy must be dropped.
        issue(255'd9, 255'd5, 255'd1, 1, 255'd9, 255'd5, 511, 1'b0, 1);
        repeat (40) @(negedge clk);
        issue(255'd4, 255'd6, 255'd2, 0, '0, '0, 0, 1'b0, 1);
        wait_done();
        repeat (20) @(negedge clk);
        chk("busy_idle", 255'(bus.o_busy), '0);

        // Async reset in the middle of the square/multiply loop.
        issue(255'd3, 255'd4, 255'd1, 0, '0, '0, 0, 1'b0, 1);
        repeat (300) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_o_x", bus.o_x, '0);
        chk("async_rst_o_y", bus.o_y, '0);
        chk("async_rst_busy", 255'(bus.o_busy), '0);
        chk("async_rst_fin", 255'(bus.o_finished), '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(255'd9, 255'd5, 255'd1, 1, 255'd9, 255'd5, 511, 1'b0, 1);
        wait_done();

        // Z = 0.
`ifdef PTA_ZCHK_EN
        issue(255'd3, 255'd4, 255'd0, 1, '0, '0, 0, 1'b1, 0);
`else
        issue(255'd3, 255'd4, 255'd0, 1, '0, '0, 511, 1'b0, 1);
`endif
        wait_done();

        // Back-to-back: next start in the cycle right after o_finished.
        issue(255'd4, 255'd6, 255'd2, 1, 255'd2, 255'd3, 511, 1'b0, 1);
        n = 0;
        while (!bus.o_finished && n < LIMIT + 100) begin
            @(negedge clk);
            n++;
        end
        issue(255'd8, 255'd8, 255'd4, 1, 255'd2, 255'd2, 511, 1'b0, 1);
        repeat (100) @(negedge clk);
        chk("held_o_x", bus.o_x, 255'd2);
        chk("held_o_y", bus.o_y, 255'd3);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/proj_to_affine.md
Name: proj_to_affine

Overview:
- Downstream of the extended-coordinate point adder; consumes its (X, Y, Z) result after the final scalar-multiplication step.
- Returns affine x = X/Z mod p and y = Y/Z mod p, with p = 2^255 - 19.
- Inversion uses Fermat: Z^(p-2), computed by left-to-right square-and-multiply on one internally instantiated Montgomery multiplier.
- Montgomery multiplier computes a*b*2^-255 mod p, with a start/finished pulse handshake and variable latency.

Parameters:
- R_MOD_P, 255'd19, 2^255 mod p (Montgomery one).
- R2_MOD_P, 255'd361, 2^510 mod p (to-Montgomery constant).
- EXP, 255'h7FFF...FFEB (p-2), fixed inversion exponent; bits scanned 254 down to 0.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset; asynchronous, active-high
- i_start  input  1  one-cycle request; sampled only in S_IDLE
- i_x  input  255  projective X, < p
- i_y  input  255  projective Y, < p
- i_z  input  255  projective Z, < p
- o_x  output  255  affine x, registered
- o_y  output  255  affine y, registered
- o_busy  output  1  high from the cycle after an accepted start until o_finished
- o_finished  output  1  one-cycle pulse when o_x/o_y are valid
- o_error  output  1  only with PTA_ZCHK_EN; see Optional Feature

Behaviour:
- Reset (async, active-high):
  - State to S_IDLE.
  - o_x, o_y, o_busy, o_finished, o_error all 0.
  - Internal acc, zm, bit counter, X/Y latches all 0; multiplier start register 0.
- Multiplications: every step drives the multiplier the same way.
  - One cycle: load registered operands and pulse start high for exactly one cycle.
  - Then wait for the multiplier's finished pulse and capture its result that cycle.
  - Never more than one multiplication in flight.
- S_IDLE:
  - On i_start, latch i_x, i_y, i_z.
  - Set acc = R_MOD_P and bit counter = 254.
  - Go to S_TOMONT.
  - i_start in any other state is ignored (no queueing).
- S_TOMONT: zm = mont(Z, R2_MOD_P) = Z*R. Then S_SQR.
- S_SQR: acc = mont(acc, acc).
  - If EXP[cnt] = 1, go to S_MUL.
  - Else if cnt = 0, go to S_XOUT.
  - Else decrement cnt and stay in S_SQR.
- S_MUL: acc = mont(acc, zm).
  - If cnt = 0, go to S_XOUT.
  - Else decrement cnt and go to S_SQR.
- S_XOUT: o_x register = mont(X, acc). Since acc = Z^-1 * R, the result is in the normal domain. Then S_YOUT.
- S_YOUT:
  - o_y register = mont(Y, acc).
  - Same cycle: o_finished = 1, then return to S_IDLE.
- Completion timing:
  - o_x and o_y update together in the o_finished cycle; o_x is staged internally until then.
  - Both hold until the next completion or reset.
- Multiplication count per operation is exactly 511: 1 to-Montgomery, 255 squares, 253 multiplies (popcount of p-2), 2 output.
- Latency from start acceptance to o_finished = 511 × (multiplier latency + 1 issue cycle) + 1.
- All results are < p; the multiplier's output range is trusted, with no extra reduction.
- Reset asserted mid-operation:
  - Immediate return to the reset values above.
  - Any in-flight multiplier result is discarded.
  - No o_finished pulse.
- Z = 0 without the macro: Z^(p-2) = 0, so o_x = o_y = 0 after the full latency.

Optional Feature:
- Macro: PTA_ZCHK_EN.
- Defined:
  - o_error port exists.
  - In S_IDLE, if a start arrives with i_z == 0, no multiplications are issued.
  - Next cycle: o_x = o_y = 0, o_finished = 1, o_error = 1, all for one cycle.
  - o_error is otherwise 0 and is cleared by reset.
- Undefined:
  - Port absent.
  - Z = 0 runs the full 511-multiplication sequence and yields 0, 0.

Test Plan:
- X=9, Y=5, Z=1, single start -> o_x=9, o_y=5; o_finished high exactly one cycle; multiplier start pulses counted = 511.
- X=4, Y=6, Z=2 -> o_x=2, o_y=3. Then X=5, Y=7, Z=p-1 -> o_x=p-5, o_y=p-7.
- Start accepted, second i_start pulsed during o_busy with different inputs -> exactly one o_finished, carrying the first operation's result; busy flag falls after the pulse.
- Reset asserted asynchronously midway through the S_SQR loop -> outputs 0 immediately with no clock edge, no o_finished. A later start with X=9, Y=5, Z=1 -> 9, 5.
- Z=0, X=3, Y=4:
  - Without PTA_ZCHK_EN -> 0, 0 after 511 multiplications.
  - With PTA_ZCHK_EN -> 0, 0 with o_error=1 one cycle after start, zero multiplier starts.
- Back-to-back: start asserted in the cycle after o_finished with X=8, Y=8, Z=4 -> accepted, result 2, 2; previous outputs held until then.
